// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// ALUOp codes (also used by ALU_Control) and datapath mux selects.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_FAULT  = 4'd12
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       fault;
  } ctrl_t;

  // States that drive mem_req and therefore run the wait-cycle timer.
  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts consecutive wait cycles of one memory access; expired flags the
// last wait cycle allowed before the access is declared stuck.
module multicycle_control_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [TMR_W-1:0] tmr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q <= '0;
    end else if (clear) begin
      tmr_q <= '0;
    end else if (count) begin
      tmr_q <= tmr_q + 1'b1;
    end
  end

  assign expired = (tmr_q == TMR_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core: sequences FETCH/DECODE/execute/
// memory/writeback over one shared req/ready memory and faults on stuck accesses.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_write,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_en,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                instr_done,
  output logic                fault,
  output logic [3:0]          dbg_state
);

  state_e state_q, state_d;
  ctrl_t  c;
  logic   in_mem;
  logic   tmr_expired;

  assign in_mem = is_mem_state(state_q);

  // Timer sits at zero outside memory states, so every access starts fresh.
  multicycle_control_mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMR_W       (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_mem || mem_ready),
    .count   (in_mem && !mem_ready),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (tmr_expired) state_d = S_FAULT;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_IEXEC;
          default:      state_d = S_FAULT;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)        state_d = S_MEMWB;
        else if (tmr_expired) state_d = S_FAULT;
      end
      S_MEMWR: begin
        if (mem_ready)        state_d = S_FETCH;
        else if (tmr_expired) state_d = S_FAULT;
      end
      S_EXEC:  state_d = S_ALUWB;
      S_IEXEC: state_d = S_IWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_IWB: state_d = S_FETCH;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes depend on mem_ready/zero in the same cycle, so decode is combinational.
  always_comb begin
    c = '0;
    case (state_q)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        if (mem_ready) begin
          c.ir_write = 1'b1;
          c.pc_en    = 1'b1;
          c.pc_src   = PCSRC_ALU;
        end
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req    = 1'b1;
        c.mem_write  = 1'b1;
        c.iord       = 1'b1;
        c.instr_done = mem_ready;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_RT;
        c.alu_op     = ALUOP_SUB;
        c.pc_src     = PCSRC_ALUOUT;
        c.pc_en      = zero;
        c.instr_done = 1'b1;
      end
      S_JUMP: begin
        c.pc_src     = PCSRC_JUMP;
        c.pc_en      = 1'b1;
        c.instr_done = 1'b1;
      end
      S_IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_IWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_FAULT: c.fault = 1'b1;
      default: c = '0;
    endcase
    if (!rst) c = '0;
  end

  assign mem_req    = c.mem_req;
  assign mem_write  = c.mem_write;
  assign iord       = c.iord;
  assign ir_write   = c.ir_write;
  assign pc_en      = c.pc_en;
  assign pc_src     = c.pc_src;
  assign reg_write  = c.reg_write;
  assign reg_dst    = c.reg_dst;
  assign mem_to_reg = c.mem_to_reg;
  assign alu_src_a  = c.alu_src_a;
  assign alu_src_b  = c.alu_src_b;
  assign alu_op     = ALUOP_W'(c.alu_op);
  assign instr_done = c.instr_done;
  assign fault      = c.fault;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected end-of-instruction events are
// queued by the driver and checked by an independent negedge monitor.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_src;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       instr_done, fault;
  logic [3:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];  // {is_fault, latency[7:0], outputs[14:0]}

  int          mon_cyc = 0;
  logic        mon_fseen = 1'b0;
  logic [23:0] mon_e;

  multicycle_control #(
    .OPCODE_W    (6),
    .ALUOP_W     (2),
    .MEM_TIMEOUT (4),
    .TMR_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .fault      (fault),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] snap_now();
    return {reg_write, reg_dst, mem_to_reg, pc_en, pc_src, mem_write,
            mem_req, iord, ir_write, alu_src_a, alu_src_b, alu_op};
  endfunction

  function automatic logic [14:0] s(input logic rw, input logic rd, input logic m2r,
                                    input logic pcen, input logic [1:0] pcs, input logic mw,
                                    input logic mreq, input logic io, input logic irw,
                                    input logic asa, input logic [1:0] asb, input logic [1:0] aop);
    return {rw, rd, m2r, pcen, pcs, mw, mreq, io, irw, asa, asb, aop};
  endfunction

  task automatic expect_ev(input logic kind, input logic [7:0] lat, input logic [14:0] sn);
    exp_q.push_back({kind, lat, sn});
  endtask

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic drive(input logic rdy);
    mem_ready = rdy;
    #3;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      drive(pat[i]);
      adv();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_cyc   = 0;
        mon_fseen = 1'b0;
      end else if (!mon_fseen) begin
        mon_cyc++;
        if (instr_done || fault) begin
          if (fault) mon_fseen = 1'b1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got done=%0b fault=%0b at cycle %0d expected no event",
                     instr_done, fault, mon_cyc);
          end else begin
            mon_e = exp_q.pop_front();
            chk("event_kind", 32'(fault), 32'(mon_e[23]));
            chk("event_latency", 32'(mon_cyc), 32'(mon_e[22:15]));
            chk("event_outputs", 32'(snap_now()), 32'(mon_e[14:0]));
          end
          mon_cyc = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; mem_ready = 1'b0; opcode = 6'd0; zero = 1'b0;
    adv();

    for (int i = 0; i < 3; i++) begin
      drive(i == 1);
      chk("reset_outputs", 32'({snap_now(), instr_done, fault}), 32'd0);
      chk("reset_state", 32'(dbg_state), 32'(S_FETCH));
      adv();
    end
    rst = 1'b1;

    // R-type, no waits: 4 cycles
    opcode = OP_RTYPE;
    expect_ev(1'b0, 8'd4, s(1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00));
    drive(1'b1);
    chk("rtype_fetch", 32'(snap_now()), 32'(s(1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,2'b01,2'b00)));
    adv();
    drive(1'b1);
    chk("rtype_decode", 32'(snap_now()), 32'(s(1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00)));
    adv();
    drive(1'b1);
    chk("rtype_exec", 32'(snap_now()), 32'(s(1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10)));
    adv();
    run(16'b1, 1);

    // lw, 2 waits in FETCH and in MEMRD: 9 cycles
    opcode = OP_LW;
    expect_ev(1'b0, 8'd9, s(1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00));
    drive(1'b0);
    chk("back_in_fetch", 32'(dbg_state), 32'(S_FETCH));
    chk("lw_fetch_wait", 32'(snap_now()), 32'(s(1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,2'b00)));
    adv();
    run(16'b1100_1110, 8);

    // beq taken then not taken: 3 cycles each
    opcode = OP_BEQ; zero = 1'b1;
    expect_ev(1'b0, 8'd3, s(1'b0,1'b0,1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01));
    run(16'b111, 3);
    zero = 1'b0;
    expect_ev(1'b0, 8'd3, s(1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01));
    run(16'b001, 3);

    // j: 3 cycles
    opcode = OP_J; zero = 1'b1;
    expect_ev(1'b0, 8'd3, s(1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00));
    run(16'b101, 3);

    // addi: 4 cycles
    opcode = OP_ADDI; zero = 1'b0;
    expect_ev(1'b0, 8'd4, s(1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00));
    run(16'b1111, 4);

    // sw, 1 FETCH wait and 3 MEMWR waits (one short of timeout): 8 cycles
    opcode = OP_SW;
    expect_ev(1'b0, 8'd8, s(1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00));
    run(16'b1000_1010, 8);

    // Illegal opcode faults the cycle after DECODE
    opcode = 6'b111111;
    expect_ev(1'b1, 8'd3, 15'd0);
    run(16'b11, 2);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1);
      chk("illegal_fault_held", 32'({fault, snap_now(), instr_done}), 32'({1'b1, 15'd0, 1'b0}));
      adv();
    end
    rst = 1'b0;
    drive(1'b1);
    chk("fault_cleared_by_rst", 32'({snap_now(), instr_done, fault}), 32'd0);
    adv();
    rst = 1'b1;

    // Timeout: MEM_TIMEOUT=4 wait cycles in FETCH
    opcode = OP_RTYPE;
    expect_ev(1'b1, 8'd5, 15'd0);
    run(16'b000, 3);
    drive(1'b0);
    chk("no_early_fault", 32'(fault), 32'd0);
    adv();
    drive(1'b1);
    chk("timeout_fault", 32'(fault), 32'd1);
    adv();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1);
      chk("fault_sticky", 32'({fault, snap_now(), instr_done}), 32'({1'b1, 15'd0, 1'b0}));
      adv();
    end
    rst = 1'b0;
    drive(1'b0);
    chk("timeout_fault_cleared", 32'({snap_now(), instr_done, fault}), 32'd0);
    adv();
    rst = 1'b1;

    // Asynchronous reset in the middle of a store
    opcode = OP_SW;
    run(16'b111, 3);
    drive(1'b0);
    chk("memwr_state", 32'(dbg_state), 32'(S_MEMWR));
    chk("memwr_req", 32'({mem_req, mem_write, iord}), 32'd7);
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({snap_now(), instr_done, fault}), 32'd0);
    chk("async_reset_state", 32'(dbg_state), 32'(S_FETCH));
    adv();
    drive(1'b0);
    adv();
    rst = 1'b1;
    drive(1'b0);
    chk("post_reset_state", 32'(dbg_state), 32'(S_FETCH));
    chk("post_reset_fetch", 32'(snap_now()), 32'(s(1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,2'b00)));
    rst = 1'b0;
    adv();
    adv();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
